// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - widths, Q8.8 twiddle constants and 17-bit reduction shared by the radix-4 butterfly
// Config macro: BUTTERFLY_SAT_EN selects saturation instead of wrap in reduce().
package fft_pkg;
  localparam int DW   = 17;
  localparam int CW   = 34;
  localparam int BUS  = 136;
  localparam int SW   = 19;
  localparam int RW   = 36;
  localparam int FRAC = 8;

  localparam logic signed [9:0] C1 = 10'sd237;
  localparam logic signed [9:0] S1 = 10'sd98;
  localparam logic signed [9:0] C2 = 10'sd181;

  // Codes 0-3 are stage-1 groups (n2 = rotation[1:0]); setting this bit selects stage 2.
  localparam logic [2:0] ROT_STAGE2 = 3'd4;

  localparam logic signed [RW-1:0] SAT_MAX = 36'sd65535;
  localparam logic signed [RW-1:0] SAT_MIN = -36'sd65536;

  typedef enum logic [1:0] {
    POST_NONE,
    POST_NEG_J,
    POST_NEG
  } post_e;

  function automatic logic signed [DW-1:0] reduce(input logic signed [RW-1:0] v);
`ifdef BUTTERFLY_SAT_EN
    if (v > SAT_MAX) return SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    else return v[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction
endpackage

// File: rtl/cmul_twiddle.sv
// rtl/cmul_twiddle.sv - combinational multiply by W16^m for m in {0,1,2,3,4,6,8,9}
// Config macro: BUTTERFLY_SAT_EN (via fft_pkg::reduce).
module cmul_twiddle
  import fft_pkg::*;
(
  input  logic signed [DW-1:0] x_re,
  input  logic signed [DW-1:0] x_im,
  input  logic [3:0]           m,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im
);
  logic                 use_mult;
  logic signed [9:0]    coef_c;
  logic signed [9:0]    coef_s;
  post_e                post;
  logic signed [RW-1:0] xr, xi, pr, pi, tr, ti;

  // m=6 and m=9 reuse the W2/W1 multiply followed by an exact -j or -1.
  always_comb begin
    use_mult = 1'b0;
    coef_c   = '0;
    coef_s   = '0;
    post     = POST_NONE;
    case (m)
      4'd1: begin use_mult = 1'b1; coef_c = C1; coef_s = S1; end
      4'd2: begin use_mult = 1'b1; coef_c = C2; coef_s = C2; end
      4'd3: begin use_mult = 1'b1; coef_c = S1; coef_s = C1; end
      4'd4: post = POST_NEG_J;
      4'd6: begin use_mult = 1'b1; coef_c = C2; coef_s = C2; post = POST_NEG_J; end
      4'd8: post = POST_NEG;
      4'd9: begin use_mult = 1'b1; coef_c = C1; coef_s = S1; post = POST_NEG; end
      default: ;
    endcase
  end

  always_comb begin
    xr = RW'(x_re);
    xi = RW'(x_im);
    pr = xr;
    pi = xi;
    if (use_mult) begin
      pr = (xr * RW'(coef_c) + xi * RW'(coef_s)) >>> FRAC;
      pi = (xi * RW'(coef_c) - xr * RW'(coef_s)) >>> FRAC;
    end
    tr = pr;
    ti = pi;
    case (post)
      POST_NEG_J: begin tr = pi;  ti = -pr; end
      POST_NEG:   begin tr = -pr; ti = -pi; end
      default: ;
    endcase
  end

  assign y_re = reduce(tr);
  assign y_im = reduce(ti);
endmodule

// File: rtl/fft16_radix4_butterfly.sv
// rtl/fft16_radix4_butterfly.sv - registered radix-4 DIF butterfly with W16 twiddle for a 16-point FFT
// Config macro: BUTTERFLY_SAT_EN saturates every 17-bit reduction instead of wrapping.
module fft16_radix4_butterfly
  import fft_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [BUS-1:0] calc_in,
  input  logic [2:0]     rotation,
  output logic [BUS-1:0] calc_out
);
  logic signed [SW-1:0] fr [4];
  logic signed [SW-1:0] fi [4];
  logic signed [SW-1:0] sr [4];
  logic signed [SW-1:0] si [4];
  logic signed [DW-1:0] yr [4];
  logic signed [DW-1:0] yi [4];
  logic signed [DW-1:0] tr [4];
  logic signed [DW-1:0] ti [4];
  logic                 stage1;
  logic [BUS-1:0]       calc_next;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fr[i] = SW'($signed(calc_in[CW*i+DW +: DW]));
      fi[i] = SW'($signed(calc_in[CW*i +: DW]));
    end
  end

  // -j*b = (b_im, -b_re); +j*d = (-d_im, d_re)
  always_comb begin
    sr[0] = fr[0] + fr[1] + fr[2] + fr[3];
    si[0] = fi[0] + fi[1] + fi[2] + fi[3];
    sr[1] = fr[0] + fi[1] - fr[2] - fi[3];
    si[1] = fi[0] - fr[1] - fi[2] + fr[3];
    sr[2] = fr[0] - fr[1] + fr[2] - fr[3];
    si[2] = fi[0] - fi[1] + fi[2] - fi[3];
    sr[3] = fr[0] - fi[1] - fr[2] + fi[3];
    si[3] = fi[0] + fr[1] - fi[2] - fr[3];
    for (int j = 0; j < 4; j++) begin
      yr[j] = reduce(RW'(sr[j]));
      yi[j] = reduce(RW'(si[j]));
    end
  end

  assign stage1 = ((rotation & ROT_STAGE2) == 3'd0);

  for (genvar j = 0; j < 4; j++) begin : g_tw
    logic [3:0] m_sel;
    assign m_sel = stage1 ? ({2'b00, rotation[1:0]} * 4'(j)) : 4'd0;

    cmul_twiddle u_tw (
      .x_re (yr[j]),
      .x_im (yi[j]),
      .m    (m_sel),
      .y_re (tr[j]),
      .y_im (ti[j])
    );
  end

  always_comb begin
    calc_next = '0;
    for (int i = 0; i < 4; i++) begin
      calc_next[CW*i +: CW] = {tr[i], ti[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) calc_out <= '0;
    else        calc_out <= calc_next;
  end
endmodule

// File: tb/tb_fft16_radix4_butterfly.sv
// tb/tb_fft16_radix4_butterfly.sv - directed self-checking bench for the radix-4 butterfly
// Config macro: BUTTERFLY_SAT_EN changes the expected overflow result.
module tb_fft16_radix4_butterfly;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [135:0] calc_in = '0;
  logic [2:0]   rotation = '0;
  logic [135:0] calc_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [135:0] s1 [4];
  logic [135:0] v;
  int           xre [16];

  fft16_radix4_butterfly dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .calc_in  (calc_in),
    .rotation (rotation),
    .calc_out (calc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] cx(input int re, input int im);
    return {re[16:0], im[16:0]};
  endfunction

  function automatic logic [135:0] bus4(input logic [33:0] f0, input logic [33:0] f1,
                                        input logic [33:0] f2, input logic [33:0] f3);
    return {f3, f2, f1, f0};
  endfunction

  task automatic step(input logic [135:0] din, input logic [2:0] rot);
    @(negedge clk);
    calc_in  = din;
    rotation = rot;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int j, input int er, input int ei);
    int gr, gi;
    gr = int'($signed(calc_out[34*j+17 +: 17]));
    gi = int'($signed(calc_out[34*j +: 17]));
    n_cmp++;
    assert (gr === er) else begin
      n_bad++;
      $error("FAIL %s f%0d.re got %0d expected %0d", tag, j, gr, er);
    end
    n_cmp++;
    assert (gi === ei) else begin
      n_bad++;
      $error("FAIL %s f%0d.im got %0d expected %0d", tag, j, gi, ei);
    end
  endtask

  task automatic chk4(input string tag, input int r0, input int i0, input int r1, input int i1,
                      input int r2, input int i2, input int r3, input int i3);
    chk(tag, 0, r0, i0);
    chk(tag, 1, r1, i1);
    chk(tag, 2, r2, i2);
    chk(tag, 3, r3, i3);
  endtask

  initial begin
    #2;
    n_cmp++;
    assert (calc_out === 136'd0) else begin
      n_bad++;
      $error("FAIL reset_state got %h expected 0", calc_out);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // DC input, stage-1 group 0
    step(bus4(cx(256, 0), cx(256, 0), cx(256, 0), cx(256, 0)), 3'd0);
    chk4("dc", 1024, 0, 0, 0, 0, 0, 0, 0);

    // b = 1.0, group 1: W16^0..W16^3 applied to (1, -j, -1, +j)
    step(bus4(cx(0, 0), cx(256, 0), cx(0, 0), cx(0, 0)), 3'd1);
    chk4("tw_g1", 256, 0, -98, -237, -181, 181, 237, 98);

    // b = 1.0, group 2: W16^0, W16^2, W16^4, W16^6
    step(bus4(cx(0, 0), cx(256, 0), cx(0, 0), cx(0, 0)), 3'd2);
    chk4("tw_g2", 256, 0, -181, -181, 0, 256, 181, -181);

    // d = 1.0, group 3: W16^0, W16^3, W16^6, W16^9
    step(bus4(cx(0, 0), cx(0, 0), cx(0, 0), cx(256, 0)), 3'd3);
    chk4("tw_g3", 256, 0, 237, 98, 181, 181, 98, 237);

    // back-to-back stage-2 vectors, one per cycle
    step(bus4(cx(1, 2), cx(3, 4), cx(5, 6), cx(7, 8)), 3'd4);
    chk4("b2b_0", 16, 20, -8, 0, -4, -4, 0, -8);
    step(bus4(cx(-10, 0), cx(0, 0), cx(0, 0), cx(0, 5)), 3'd5);
    chk4("b2b_1", -10, 5, -15, 0, -10, -5, -5, 0);
    step(bus4(cx(0, 0), cx(0, 0), cx(0, 0), cx(256, 0)), 3'd7);
    chk4("b2b_2", 256, 0, 0, 256, -256, 0, 0, -256);

    // overflow of the 19-bit sum into 17 bits
    step(bus4(cx(25600, 0), cx(25600, 0), cx(25600, 0), cx(25600, 0)), 3'd4);
`ifdef BUTTERFLY_SAT_EN
    chk4("ovf", 65535, 0, 0, 0, 0, 0, 0, 0);
`else
    chk4("ovf", -28672, 0, 0, 0, 0, 0, 0, 0);
`endif

    // impulse at x[0] through both stages
    for (int n2 = 0; n2 < 4; n2++) begin
      step(bus4(cx(n2 == 0 ? 256 : 0, 0), cx(0, 0), cx(0, 0), cx(0, 0)), 3'(n2));
      s1[n2] = calc_out;
    end
    for (int k1 = 0; k1 < 4; k1++) begin
      step(bus4(s1[0][34*k1 +: 34], s1[1][34*k1 +: 34], s1[2][34*k1 +: 34], s1[3][34*k1 +: 34]),
           3'(4 + k1));
      for (int k2 = 0; k2 < 4; k2++) chk($sformatf("imp_X%0d", k1 + 4*k2), k2, 256, 0);
    end

    // cosine at bin 1, amplitude 1.0; exact Q8.8 results including floor error
    foreach (xre[k]) xre[k] = 0;
    xre[1] = 2049; xre[5] = 1; xre[9] = -3; xre[13] = 1;
    xre[7] = -4; xre[15] = 2052;
    step(bus4(cx(256, 0), cx(0, 0), cx(-256, 0), cx(0, 0)), 3'd0);
    s1[0] = calc_out;
    step(bus4(cx(237, 0), cx(-98, 0), cx(-237, 0), cx(98, 0)), 3'd1);
    s1[1] = calc_out;
    step(bus4(cx(181, 0), cx(-181, 0), cx(-181, 0), cx(181, 0)), 3'd2);
    s1[2] = calc_out;
    step(bus4(cx(98, 0), cx(-237, 0), cx(-98, 0), cx(237, 0)), 3'd3);
    s1[3] = calc_out;
    for (int k1 = 0; k1 < 4; k1++) begin
      step(bus4(s1[0][34*k1 +: 34], s1[1][34*k1 +: 34], s1[2][34*k1 +: 34], s1[3][34*k1 +: 34]),
           3'(4 + k1));
      for (int k2 = 0; k2 < 4; k2++)
        chk($sformatf("cos_X%0d", k1 + 4*k2), k2, xre[k1 + 4*k2], 0);
    end

    // asynchronous reset mid-stream
    v = bus4(cx(100, -3), cx(7, 9), cx(-50, 2), cx(1, 1));
    step(v, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    assert (calc_out === 136'd0) else begin
      n_bad++;
      $error("FAIL async_reset got %h expected 0", calc_out);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    assert (calc_out === 136'd0) else begin
      n_bad++;
      $error("FAIL reset_hold got %h expected 0", calc_out);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    calc_in  = bus4(cx(256, 0), cx(0, 0), cx(0, 0), cx(0, 0));
    rotation = 3'd4;
    @(posedge clk);
    #1;
    chk4("post_reset", 256, 0, 256, 0, 256, 0, 256, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
